led_bank: RTL and testbench
===========================

LED_BANK -- requirements
Module: led_bank

Interface
REQ-001: Parameter NumLeds, default 4: number of independent LED channels, legal range 2..16.
REQ-002: Parameter CounterWidth, default 24: width of the half-period counter and of cfg_half_period_i.
REQ-003: Parameter CountWidth, default 8: width of the burst pulse count.
REQ-004: clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005: rst_i  input  1: reset, synchronous and active-high.
REQ-006: cfg_valid_i  input  1: configuration request valid.
REQ-007: cfg_ready_o  output  1: block can accept a configuration request.
REQ-008: cfg_chan_i  input  $clog2(NumLeds): target channel index.
REQ-009: cfg_mode_i  input  2: requested mode, encoded OFF=0, ON=1, BLINK=2, BURST=3.
REQ-010: cfg_half_period_i  input  CounterWidth: cycles per LED high phase and per LED low phase.
REQ-011: cfg_count_i  input  CountWidth: number of high pulses in BURST mode.
REQ-012: led_o  output  NumLeds: per-channel LED drive, registered.
REQ-013: busy_o  output  NumLeds: channel is in BLINK or in an unfinished BURST.
REQ-014: done_o  output  NumLeds: one-cycle pulse when a BURST completes.

Function
REQ-015: A request SHALL be accepted on a rising edge where cfg_valid_i and cfg_ready_o are both 1; only the channel given by cfg_chan_i is affected.
REQ-016: cfg_ready_o SHALL be 0 during reset and in the first cycle after reset deasserts, and 1 at all other times.
REQ-017: A cfg_chan_i value >= NumLeds SHALL be accepted and ignored, with no channel state change.
REQ-018: A half period of 0 SHALL be treated as 1.
REQ-019: OFF: led_o[c]=0 and busy_o[c]=0 from the cycle after acceptance.
REQ-020: ON: led_o[c]=1 and busy_o[c]=0 from the cycle after acceptance.
REQ-021: BLINK: led_o[c]=1 from the cycle after acceptance, then alternates indefinitely: high for H cycles, low for H cycles (H = effective half period); busy_o[c]=1 throughout.
REQ-022: BURST with N>0: led_o[c] produces N periods of H cycles high then H cycles low, starting high in the cycle after acceptance; busy_o[c]=1 for those 2*N*H cycles.
REQ-023: BURST completion: in the cycle after the last low phase, done_o[c]=1 for exactly one cycle, busy_o[c]=0, and the channel mode becomes OFF.
REQ-024: BURST with N=0: led_o[c] stays 0, and done_o[c] pulses in the cycle after acceptance.
REQ-025: A request to a busy channel SHALL abort the current activity, restart the phase counter, and apply the new mode with REQ-019..024 timing; the aborted burst produces no done_o pulse.
REQ-026: Channels SHALL be fully independent; multiple channels may complete in the same cycle.
REQ-027: Phase counters SHALL be CounterWidth bits; the pulse counter SHALL be CountWidth bits; neither shall wrap during legal operation.

Reset
REQ-028: While rst_i=1 at a rising edge, every channel SHALL enter OFF with counters cleared, and led_o, busy_o, done_o and cfg_ready_o SHALL be 0.
REQ-029: Reset asserted mid-BLINK or mid-BURST SHALL abort the activity without a done_o pulse.
REQ-030: A request presented while rst_i=1 SHALL be ignored.

Structure
REQ-031: Package led_bank_pkg SHALL hold the mode enum type (led_mode_e, 2 bits) and the mode encodings.
REQ-032: Per-channel logic SHALL be a sub-module led_channel, instantiated NumLeds times by a generate loop; led_bank contains only request decode and ready logic.

Verification
REQ-033: Reset for 2 cycles, then idle: cfg_ready_o rises on the 2nd cycle after reset release; led_o=0, busy_o=0, done_o=0.
REQ-034: Channel 1 set to BLINK with H=5: led_o[1] goes high for 5 cycles, then low for 5 cycles, repeating for at least 3 periods; other channels stay 0.
REQ-035: Channel 2 set to BURST with H=3, N=4: exactly 4 high pulses of 3 cycles; busy_o[2] high for 24 cycles; done_o[2] pulses once in cycle 25; the channel then remains OFF.
REQ-036: Channel 0 set to BURST with N=0: led_o[0] stays 0; done_o[0] pulses in the cycle after acceptance.
REQ-037: Channel 3 set to BURST with H=4, N=10, then set to ON after 13 cycles: led_o[3]=1 from the following cycle; no done_o[3] pulse occurs.
REQ-038: Channel 1 in BLINK with H=2, rst_i asserted mid-high phase: all outputs are 0 at the next edge; no done_o pulse occurs; after reset, channel 1 stays OFF.

Source files
------------

// File: rtl/led_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_bank_pkg: shared mode encoding for the LED bank                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package led_bank_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } led_mode_e;

    // Modes that run the phase counter.
    function automatic logic is_periodic(input led_mode_e mode);
        return (mode == MODE_BLINK) || (mode == MODE_BURST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_channel: one LED driver supporting OFF/ON/BLINK/BURST           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module led_channel
    import led_bank_pkg::*;
#(
    parameter int CounterWidth = 24,
    parameter int CountWidth   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    input  logic [1:0]              cmd_mode_i,
    input  logic [CounterWidth-1:0] cmd_half_i,
    input  logic [CountWidth-1:0]   cmd_count_i,
    output logic                    led_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [CounterWidth-1:0] PHASE_ONE = CounterWidth'(1);
    localparam logic [CountWidth-1:0]   PULSE_ONE = CountWidth'(1);

    led_mode_e               mode_q;
    logic [CounterWidth-1:0] phase_q;
    logic [CounterWidth-1:0] half_q;
    logic [CountWidth-1:0]   pulses_q;
    logic                    led_q;
    logic                    busy_q;
    logic                    done_q;

    led_mode_e cmd_mode;
    logic      phase_end;
    logic      last_low;

    assign cmd_mode  = led_mode_e'(cmd_mode_i);
    assign phase_end = (phase_q == half_q - PHASE_ONE);
    // End of the low phase of the final burst period.
    assign last_low  = (mode_q == MODE_BURST) && !led_q && (pulses_q == PULSE_ONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= MODE_OFF;
            phase_q  <= '0;
            half_q   <= PHASE_ONE;
            pulses_q <= '0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (cmd_valid_i) begin
            phase_q  <= '0;
            half_q   <= cmd_half_i;
            pulses_q <= cmd_count_i;
            done_q   <= 1'b0;
            case (cmd_mode)
                MODE_ON: begin
                    mode_q <= MODE_ON;
                    led_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                MODE_BLINK: begin
                    mode_q <= MODE_BLINK;
                    led_q  <= 1'b1;
                    busy_q <= 1'b1;
                end
                MODE_BURST: begin
                    if (cmd_count_i == '0) begin
                        mode_q <= MODE_OFF;
                        led_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        mode_q <= MODE_BURST;
                        led_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    mode_q <= MODE_OFF;
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end else begin
            done_q <= 1'b0;
            if (is_periodic(mode_q)) begin
                if (!phase_end) begin
                    phase_q <= phase_q + PHASE_ONE;
                end else begin
                    phase_q <= '0;
                    if (last_low) begin
                        mode_q   <= MODE_OFF;
                        led_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pulses_q <= '0;
                    end else begin
                        led_q <= ~led_q;
                        if ((mode_q == MODE_BURST) && !led_q) begin
                            pulses_q <= pulses_q - PULSE_ONE;
                        end
                    end
                end
            end
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/led_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_bank: request decode and ready logic over NumLeds LED channels  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module led_bank
    import led_bank_pkg::*;
#(
    parameter int NumLeds      = 4,
    parameter int CounterWidth = 24,
    parameter int CountWidth   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [$clog2(NumLeds)-1:0] cfg_chan_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic [CounterWidth-1:0]    cfg_half_period_i,
    input  logic [CountWidth-1:0]      cfg_count_i,
    output logic [NumLeds-1:0]         led_o,
    output logic [NumLeds-1:0]         busy_o,
    output logic [NumLeds-1:0]         done_o
);

    logic                    ready_q;
    logic                    accept;
    logic [NumLeds-1:0]      chan_sel;
    logic [CounterWidth-1:0] half_eff;

    // Ready stays low for one cycle after reset release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cfg_ready_o = ready_q;
    assign accept      = cfg_valid_i && ready_q && !rst_i;
    assign half_eff    = (cfg_half_period_i == '0) ? CounterWidth'(1) : cfg_half_period_i;

    // Indices outside the bank match no channel, so such requests are dropped.
    always_comb begin
        chan_sel = '0;
        for (int i = 0; i < NumLeds; i++) begin
            chan_sel[i] = accept && (32'(cfg_chan_i) == 32'(i));
        end
    end

    for (genvar g = 0; g < NumLeds; g++) begin : g_chan
        led_channel #(
            .CounterWidth (CounterWidth),
            .CountWidth   (CountWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .cmd_valid_i (chan_sel[g]),
            .cmd_mode_i  (cfg_mode_i),
            .cmd_half_i  (half_eff),
            .cmd_count_i (cfg_count_i),
            .led_o       (led_o[g]),
            .busy_o      (busy_o[g]),
            .done_o      (done_o[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_bank: randomized and directed bench with a timeline model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_led_bank;

    localparam int NL = 4;
    localparam int CW = 24;
    localparam int KW = 8;
    localparam int VW = 1 + 3 * NL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [1:0]    cfg_mode = '0;
    logic [CW-1:0] cfg_half = '0;
    logic [KW-1:0] cfg_count = '0;
    logic [NL-1:0] led, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    led_bank #(.NumLeds(NL), .CounterWidth(CW), .CountWidth(KW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cfg_valid_i       (cfg_valid),
        .cfg_ready_o       (cfg_ready),
        .cfg_chan_i        (cfg_chan),
        .cfg_mode_i        (cfg_mode),
        .cfg_half_period_i (cfg_half),
        .cfg_count_i       (cfg_count),
        .led_o             (led),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    // Model: each channel remembers its last request and the edge it landed on;
    // outputs are then a pure function of elapsed cycles.
    int edge_n    = 0;
    int since_rst = 0;
    int m_mode  [NL];
    int m_start [NL];
    int m_h     [NL];
    int m_n     [NL];

    initial for (int c = 0; c < NL; c++) begin
        m_mode[c] = 0; m_start[c] = 0; m_h[c] = 1; m_n[c] = 0;
    end

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            since_rst = 0;
            for (int c = 0; c < NL; c++) m_mode[c] = 0;
        end else begin
            if (cfg_valid && since_rst >= 1 && int'(cfg_chan) < NL) begin
                m_mode[cfg_chan]  = int'(cfg_mode);
                m_start[cfg_chan] = edge_n;
                m_h[cfg_chan]     = (cfg_half == 0) ? 1 : int'(cfg_half);
                m_n[cfg_chan]     = int'(cfg_count);
            end
            since_rst = since_rst + 1;
        end
    end

    // {ready, done, busy, led}
    function automatic logic [VW-1:0] expected();
        logic [NL-1:0] l, b, d;
        int k, h, n;
        l = '0; b = '0; d = '0;
        for (int c = 0; c < NL; c++) begin
            k = edge_n - m_start[c];
            h = m_h[c];
            n = m_n[c];
            case (m_mode[c])
                1: l[c] = 1'b1;
                2: begin
                    l[c] = ((k / h) % 2) == 0;
                    b[c] = 1'b1;
                end
                3: begin
                    if (k < 2 * n * h) begin
                        l[c] = ((k / h) % 2) == 0;
                        b[c] = 1'b1;
                    end else begin
                        d[c] = (k == 2 * n * h);
                    end
                end
                default: ;
            endcase
        end
        return {since_rst >= 1, d, b, l};
    endfunction

    task automatic drive(input logic v, input int ch, input int md, input int h, input int n);
        cfg_valid = v;
        cfg_chan  = 2'(ch);
        cfg_mode  = 2'(md);
        cfg_half  = CW'(h);
        cfg_count = KW'(n);
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_v;
        logic ready_req [3];
        ready_req[0] = 1'b0; ready_req[1] = 1'b1; ready_req[2] = 1'b1;
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            n_cmp++;
            if (cfg_ready !== ready_req[i]) begin
                n_err++;
                $display("FAIL reset_ready cyc%0d: got %b want %b", i, cfg_ready, ready_req[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blink();
        logic [VW-1:0] exp_v;
        int rises = 0, highs = 0;
        logic prev = 1'b0;
        for (int i = 0; i <= 36; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL blink cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (i >= 1 && i <= 30) begin
                if (led[1] && !prev) rises++;
                if (led[1]) highs++;
                prev = led[1];
            end
            if (i == 0) drive(1'b1, 1, 2, 5, 0);
            else        drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
        n_cmp++;
        if (rises !== 3 || highs !== 15) begin
            n_err++;
            $display("FAIL blink_shape: got rises=%0d highs=%0d want 3/15", rises, highs);
        end
    endtask

    task automatic test_burst();
        logic [VW-1:0] exp_v;
        int rises = 0, busy_n = 0, done_n = 0, done_at = -1;
        logic prev = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL burst cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (i >= 1) begin
                if (led[2] && !prev) rises++;
                prev = led[2];
                if (busy[2]) busy_n++;
                if (done[2]) begin done_n++; done_at = i; end
            end
            if (i == 0) drive(1'b1, 2, 3, 3, 4);
            else        drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
        n_cmp++;
        if (rises !== 4 || busy_n !== 24 || done_n !== 1 || done_at !== 25 || led[2] !== 1'b0) begin
            n_err++;
            $display("FAIL burst_shape: got rises=%0d busy=%0d done=%0d at %0d want 4/24/1 at 25",
                     rises, busy_n, done_n, done_at);
        end
    endtask

    task automatic test_burst_zero();
        logic [VW-1:0] exp_v;
        int done_at = -1, led_hi = 0;
        for (int i = 0; i <= 4; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL burst_zero cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (i >= 1 && done[0]) done_at = i;
            if (i >= 1 && led[0]) led_hi++;
            if (i == 0) drive(1'b1, 0, 3, 7, 0);
            else        drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
        n_cmp++;
        if (done_at !== 1 || led_hi !== 0) begin
            n_err++;
            $display("FAIL burst_zero_shape: got done_at=%0d led_hi=%0d want 1/0", done_at, led_hi);
        end
    endtask

    task automatic test_abort();
        logic [VW-1:0] exp_v;
        int done_n = 0, on_n = 0;
        for (int i = 0; i <= 60; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL abort cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (done[3]) done_n++;
            if (i >= 14 && led[3] && !busy[3]) on_n++;
            if (i == 0)       drive(1'b1, 3, 3, 4, 10);
            else if (i == 13) drive(1'b1, 3, 1, 4, 10);
            else              drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
        n_cmp++;
        if (done_n !== 0 || on_n !== 47) begin
            n_err++;
            $display("FAIL abort_shape: got done=%0d on=%0d want 0/47", done_n, on_n);
        end
    endtask

    task automatic test_half_zero();
        logic [VW-1:0] exp_v;
        for (int i = 0; i <= 8; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL half_zero cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (i == 0) drive(1'b1, 0, 2, 0, 0);
            else        drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] exp_v;
        int done_n = 0, led_hi = 0;
        for (int i = 0; i <= 14; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if (i >= 2) begin
                if (done !== '0) done_n++;
                if (led[1]) led_hi++;
            end
            rst = (i == 1 || i == 2);
            if (i == 0)      drive(1'b1, 1, 2, 2, 0);
            else if (i == 2) drive(1'b1, 0, 1, 0, 0);
            else             drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
        n_cmp++;
        if (done_n !== 0 || led_hi !== 0 || led !== '0) begin
            n_err++;
            $display("FAIL reset_mid_shape: got done=%0d led1_hi=%0d led=%b want 0/0/0000",
                     done_n, led_hi, led);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            exp_v = expected();
            n_cmp++;
            if ({cfg_ready, done, busy, led} !== exp_v) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, {cfg_ready, done, busy, led}, exp_v);
            end
            if ($urandom_range(0, 9) < 3)
                drive(1'b1, $urandom_range(0, NL - 1), $urandom_range(0, 3),
                      $urandom_range(0, 4), $urandom_range(0, 3));
            else
                drive(1'b0, 0, 0, 0, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_burst();
        test_burst_zero();
        test_abort();
        test_half_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
